// File: rtl/kamus_lsu_ctrl.sv
// Load/store sequencer between EX and L1D: aligns store lanes, runs the req/gnt/rvalid
// handshake with a timeout, and extends returned load data for writeback.
module kamus_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter bit          STORE_ACK      = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [4:0]  lsu_rd_i,
  output logic        lsu_busy_o,
  output logic        lsu_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    off_q, off_d;
  logic [4:0]    rd_q, rd_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          err_q, err_d;
  logic          wb_valid_q, wb_valid_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;

  logic          f3_legal_s, aligned_s, req_ok_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s, shifted_s, load_ext_s;
  logic          done_s, go_wait_s, timeout_s;

  // Legality checks on the incoming request; stores only allow B/H/W.
  always_comb begin
    f3_legal_s = 1'b0;
    aligned_s  = 1'b0;
    case (lsu_funct3_i)
      3'b000: begin f3_legal_s = 1'b1;      aligned_s = 1'b1;                   end
      3'b001: begin f3_legal_s = 1'b1;      aligned_s = ~lsu_addr_i[0];         end
      3'b010: begin f3_legal_s = 1'b1;      aligned_s = (lsu_addr_i[1:0] == 2'b00); end
      3'b100: begin f3_legal_s = ~lsu_we_i; aligned_s = 1'b1;                   end
      3'b101: begin f3_legal_s = ~lsu_we_i; aligned_s = ~lsu_addr_i[0];         end
      default: begin f3_legal_s = 1'b0;     aligned_s = 1'b0;                   end
    endcase
    req_ok_s = f3_legal_s & aligned_s;
  end

  always_comb begin
    case (lsu_funct3_i[1:0])
      2'b00: begin
        be_s    = 4'b0001 << lsu_addr_i[1:0];
        wdata_s = {4{lsu_wdata_i[7:0]}};
      end
      2'b01: begin
        be_s    = 4'b0011 << lsu_addr_i[1:0];
        wdata_s = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        be_s    = 4'b1111;
        wdata_s = lsu_wdata_i;
      end
    endcase
    if (!lsu_we_i) begin
      wdata_s = 32'h0000_0000;
    end else begin
      wdata_s = wdata_s;
    end
  end

  always_comb begin
    shifted_s = mem_rdata_i >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
      3'b100:  load_ext_s = {24'h00_0000, shifted_s[7:0]};
      3'b001:  load_ext_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
      3'b101:  load_ext_s = {16'h0000, shifted_s[15:0]};
      default: load_ext_s = mem_rdata_i;
    endcase
  end

  // Grant with rvalid in the same cycle retires straight from S_REQ.
  always_comb begin
    done_s    = 1'b0;
    go_wait_s = 1'b0;
    case (state_q)
      S_REQ: begin
        if (mem_gnt_i) begin
          if ((we_q && !STORE_ACK) || mem_rvalid_i) begin
            done_s = 1'b1;
          end else begin
            go_wait_s = 1'b1;
          end
        end else begin
          done_s = 1'b0;
        end
      end
      S_WAIT:  done_s = mem_rvalid_i;
      default: done_s = 1'b0;
    endcase
    timeout_s = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = 1'b0;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    case (state_q)
      S_IDLE: begin
        mem_req_d = 1'b0;
        if (lsu_req_i && req_ok_s) begin
          state_d     = S_REQ;
          cnt_d       = '0;
          we_d        = lsu_we_i;
          funct3_d    = lsu_funct3_i;
          off_d       = lsu_addr_i[1:0];
          rd_d        = lsu_rd_i;
          mem_req_d   = 1'b1;
          mem_addr_d  = {lsu_addr_i[31:2], 2'b00};
          mem_be_d    = be_s;
          mem_wdata_d = wdata_s;
        end else if (lsu_req_i) begin
          err_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ, S_WAIT: begin
        if (done_s) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          if (!we_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = load_ext_s;
          end else begin
            wb_valid_d = 1'b0;
          end
        end else if (timeout_s) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (go_wait_s) begin
            state_d   = S_WAIT;
            mem_req_d = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      rd_q        <= 5'd0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
      err_q       <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign lsu_busy_o  = (state_q == S_IDLE) ? (lsu_req_i & req_ok_s) : 1'b1;
  assign lsu_err_o   = err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;

endmodule

// File: tb/tb_kamus_lsu_ctrl.sv
// Self-checking bench for kamus_lsu_ctrl: directed vectors, error/timeout/reset cases and
// randomized accesses compared against an arithmetic reference model.
module tb_kamus_lsu_ctrl;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_req = 1'b0, lsu_we = 1'b0;
  logic [2:0]  lsu_funct3 = 3'b000;
  logic [31:0] lsu_addr = 32'h0, lsu_wdata = 32'h0;
  logic [4:0]  lsu_rd = 5'd0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        lsu_busy, lsu_err, mem_req, mem_we, wb_valid;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_be;
  logic [4:0]  wb_rd;

  int n_checks = 0;
  int n_fail   = 0;

  kamus_lsu_ctrl #(.TIMEOUT_CYCLES(T), .STORE_ACK(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_funct3_i(lsu_funct3),
    .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata), .lsu_rd_i(lsu_rd),
    .lsu_busy_o(lsu_busy), .lsu_err_o(lsu_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] off);
    int lanes;
    int pat;
    lanes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    pat = ((1 << lanes) - 1) << ((lanes == 4) ? 0 : int'(off));
    return pat[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic [31:0] sh, v;
    sh = rdata >> (8 * int'(off));
    case (f3)
      3'b000:  begin v = sh & 32'hFF;   return (v >= 32'd128)   ? v + 32'hFFFF_FF00 : v; end
      3'b100:  return sh & 32'hFF;
      3'b001:  begin v = sh & 32'hFFFF; return (v >= 32'd32768) ? v + 32'hFFFF_0000 : v; end
      3'b101:  return sh & 32'hFFFF;
      default: return rdata;
    endcase
  endfunction

  // One legal access: gd cycles of grant delay, rw cycles of rvalid delay, optional gnt+rvalid together.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [4:0] rd, input int gd,
                            input int rw, input logic [31:0] rdata, input logic same);
    logic [31:0] e_addr, e_wd, e_wb;
    logic [3:0]  e_be;
    e_addr = addr & 32'hFFFF_FFFC;
    e_be   = model_be(f3, addr[1:0]);
    e_wd   = we ? model_wdata(f3, wd) : 32'h0;
    e_wb   = model_load(f3, addr[1:0], rdata);
    lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd; lsu_rd = rd;
    #1;
    n_checks++;
    if (lsu_busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_accept: got %b want 1", lsu_busy);
    end
    @(negedge clk);
    for (int i = 0; i <= gd; i++) begin
      lsu_req = (i < gd) ? 1'b1 : 1'b0;
      lsu_addr = $urandom & 32'hFFFF_FFFC; lsu_funct3 = 3'b010; lsu_wdata = $urandom;
      #1;
      n_checks++;
      if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, lsu_busy, lsu_err} !==
          {1'b1, we, e_addr, e_be, e_wd, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL req_phase: got req=%b we=%b addr=%h be=%b wd=%h busy=%b err=%b want we=%b addr=%h be=%b wd=%h",
                 mem_req, mem_we, mem_addr, mem_be, mem_wdata, lsu_busy, lsu_err, we, e_addr, e_be, e_wd);
      end
      if (i == gd) begin
        mem_gnt = 1'b1;
        if (same) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
      end
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
    end
    if (!we) begin
      if (!same) begin
        for (int i = 0; i <= rw; i++) begin
          #1;
          n_checks++;
          if ({mem_req, lsu_busy, wb_valid} !== 3'b010) begin
            n_fail++; $display("FAIL wait_phase: got req=%b busy=%b wbv=%b want 0 1 0", mem_req, lsu_busy, wb_valid);
          end
          if (i == rw) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
          @(negedge clk);
          mem_rvalid = 1'b0; mem_rdata = $urandom;
        end
      end
      #1;
      n_checks++;
      if ({wb_valid, wb_rd, wb_data, lsu_busy, lsu_err, mem_req} !== {1'b1, rd, e_wb, 3'b000}) begin
        n_fail++;
        $display("FAIL load_wb: got v=%b rd=%0d data=%h busy=%b err=%b req=%b want rd=%0d data=%h",
                 wb_valid, wb_rd, wb_data, lsu_busy, lsu_err, mem_req, rd, e_wb);
      end
      @(negedge clk);
      n_checks++;
      if (wb_valid !== 1'b0) begin
        n_fail++; $display("FAIL wb_pulse_width: got %b want 0", wb_valid);
      end
    end else begin
      #1;
      n_checks++;
      if ({mem_req, lsu_busy, wb_valid, lsu_err} !== 4'b0000) begin
        n_fail++; $display("FAIL store_retire: got req=%b busy=%b wbv=%b err=%b want 0000",
                           mem_req, lsu_busy, wb_valid, lsu_err);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({lsu_busy, lsu_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_valid, wb_rd, wb_data} !== 113'd0) begin
      n_fail++; $display("FAIL reset_outputs: got req=%b busy=%b wbv=%b addr=%h want all 0",
                         mem_req, lsu_busy, wb_valid, mem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_spec_vectors();
    run_access(1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd7, 0, 0, 32'h80FF_1234, 1'b0);
    run_access(1'b0, 3'b101, 32'h0000_2002, 32'h0, 5'd9, 0, 0, 32'hBEEF_0000, 1'b0);
    run_access(1'b1, 3'b001, 32'h0000_0012, 32'h1234_ABCD, 5'd0, 3, 0, 32'h0, 1'b0);
    run_access(1'b0, 3'b010, 32'h0000_0104, 32'h0, 5'd31, 2, 3, 32'hCAFE_F00D, 1'b0);
  endtask

  task automatic test_illegal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = $urandom;
    #1;
    n_checks++;
    if (lsu_busy !== 1'b0) begin
      n_fail++; $display("FAIL illegal_busy f3=%b addr=%h: got %b want 0", f3, addr, lsu_busy);
    end
    @(negedge clk);
    lsu_req = 1'b0;
    #1;
    n_checks++;
    if ({lsu_err, mem_req, lsu_busy} !== 3'b100) begin
      n_fail++; $display("FAIL illegal_err f3=%b addr=%h: got err=%b req=%b busy=%b want 1 0 0",
                         f3, addr, lsu_err, mem_req, lsu_busy);
    end
    @(negedge clk);
    n_checks++;
    if ({lsu_err, mem_req} !== 2'b00) begin
      n_fail++; $display("FAIL illegal_pulse: got err=%b req=%b want 0 0", lsu_err, mem_req);
    end
  endtask

  task automatic test_timeout(input logic grant);
    int busy_cycles;
    logic saw_wb;
    busy_cycles = 0; saw_wb = 1'b0;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h40; lsu_rd = 5'd3;
    @(negedge clk);
    lsu_req = 1'b0;
    for (int i = 0; i < 4 * T; i++) begin
      #1;
      if (lsu_busy !== 1'b1) break;
      if (wb_valid === 1'b1) saw_wb = 1'b1;
      busy_cycles++;
      mem_gnt = grant && (i == 0);
      @(negedge clk);
      mem_gnt = 1'b0;
    end
    n_checks++;
    if ({busy_cycles, lsu_err, mem_req, wb_valid, saw_wb} !== {T, 4'b1000}) begin
      n_fail++; $display("FAIL timeout grant=%b: got cycles=%0d err=%b req=%b wbv=%b want cycles=%0d err=1",
                         grant, busy_cycles, lsu_err, mem_req, wb_valid | saw_wb, T);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b000; lsu_addr = 32'h81; lsu_rd = 5'd5;
    @(negedge clk);
    lsu_req = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if ({lsu_busy, lsu_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_valid, wb_rd, wb_data} !== 113'd0) begin
        n_fail++; $display("FAIL reset_mid_access: got wbv=%b err=%b req=%b busy=%b want all 0",
                           wb_valid, lsu_err, mem_req, lsu_busy);
      end
      @(negedge clk);
    end
    run_access(1'b0, 3'b001, 32'h0000_0082, 32'h0, 5'd12, 1, 1, 32'h8001_7FFF, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 5'd0, 0, 0, 32'h0, 1'b0);
    run_access(1'b0, 3'b000, 32'h0000_0202, 32'h0, 5'd1, 0, 0, 32'h00F0_0000, 1'b1);
    run_access(1'b1, 3'b010, 32'h0000_0204, 32'hDEAD_BEEF, 5'd0, 0, 0, 32'h0, 1'b0);
    run_access(1'b0, 3'b100, 32'h0000_0207, 32'h0, 5'd2, 1, 0, 32'hF100_0000, 1'b1);
  endtask

  task automatic test_random();
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      we = $urandom_range(0, 1);
      case ($urandom_range(0, we ? 2 : 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      a = $urandom;
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      run_access(we, f3, a, $urandom, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom, (!we) && ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_spec_vectors();
    test_illegal(1'b0, 3'b010, 32'h0000_0001);
    test_illegal(1'b0, 3'b001, 32'h0000_0003);
    test_illegal(1'b1, 3'b010, 32'h0000_0002);
    test_illegal(1'b1, 3'b100, 32'h0000_0000);
    test_illegal(1'b0, 3'b011, 32'h0000_0000);
    test_illegal(1'b0, 3'b110, 32'h0000_0000);
    test_timeout(1'b1);
    test_timeout(1'b0);
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
